// File: rtl/ysyx_23060303_pkg.sv
// Shared definitions for the ysyx_23060303 multi-cycle RV32I-subset core:
// opcode constants, the ebreak encoding, FSM state encoding and halt reason codes.
package ysyx_23060303_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam logic [1:0] REASON_NONE    = 2'b00;
    localparam logic [1:0] REASON_EBREAK  = 2'b01;
    localparam logic [1:0] REASON_ILLEGAL = 2'b10;

    // True when a 5-bit register index names an implemented register.
    function automatic logic reg_idx_ok(input logic [4:0] idx, input int nr_regs);
        return (int'({27'd0, idx}) < nr_regs);
    endfunction

endpackage

// File: rtl/ysyx_23060303_regfile_p.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, asynchronous active-low clear. x0 and unimplemented indices read 0.
module ysyx_23060303_regfile_p
    import ysyx_23060303_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NR_REGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    localparam int AW = (NR_REGS > 1) ? $clog2(NR_REGS) : 1;

    logic [XLEN-1:0] regs_q [NR_REGS];

    // Register storage: cleared on reset, written when enabled and not x0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != 5'd0) && reg_idx_ok(waddr, NR_REGS)) begin
            regs_q[waddr[AW-1:0]] <= wdata;
        end
    end

    // Read port 1: x0 and out-of-range indices return zero.
    always_comb begin
        if ((raddr1 == 5'd0) || !reg_idx_ok(raddr1, NR_REGS)) begin
            rdata1 = '0;
        end else begin
            rdata1 = regs_q[raddr1[AW-1:0]];
        end
    end

    // Read port 2: x0 and out-of-range indices return zero.
    always_comb begin
        if ((raddr2 == 5'd0) || !reg_idx_ok(raddr2, NR_REGS)) begin
            rdata2 = '0;
        end else begin
            rdata2 = regs_q[raddr2[AW-1:0]];
        end
    end

endmodule

// File: rtl/ysyx_23060303_mc_cputop.sv
// Multi-cycle RV32I-subset core (addi/add/lui/auipc/jal/jalr/ebreak).
// FETCH -> WAIT -> EXEC -> FETCH over a valid/ready instruction port; halts on
// ebreak or illegal instruction and reports the reason plus a0.
// Optional feature macro: COMMIT_TRACE_EN adds a registered per-retire commit trace.
module ysyx_23060303_mc_cputop
    import ysyx_23060303_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NR_REGS  = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_vld,
    input  logic            imem_req_rdy,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_vld,
    input  logic [31:0]     imem_rsp_data,
    output logic            halt,
    output logic [1:0]      halt_reason,
    output logic [XLEN-1:0] halt_code,
    output logic [XLEN-1:0] pc
`ifdef COMMIT_TRACE_EN
    ,
    output logic            commit_vld,
    output logic [XLEN-1:0] commit_pc,
    output logic [31:0]     commit_inst,
    output logic            commit_wen,
    output logic [4:0]      commit_rd,
    output logic [XLEN-1:0] commit_wdata
`endif
);

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);
    localparam logic [XLEN-1:0] JALR_MASK = ~(XLEN'(32'd1));

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            req_vld_q, req_vld_d;
    logic            halt_q, halt_d;
    logic [1:0]      halt_reason_q, halt_reason_d;
    logic [XLEN-1:0] halt_code_q, halt_code_d;

    logic [6:0]      opcode_s;
    logic [4:0]      rd_s, rs1_s, rs2_s, raddr2_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [XLEN-1:0] imm_i_s, imm_u_s, imm_j_s;
    logic [XLEN-1:0] rs1_data_s, rs2_data_s;
    logic [XLEN-1:0] pc_plus4_s, jal_tgt_s, jalr_tgt_s;
    logic [XLEN-1:0] wdata_s, next_pc_s;
    logic            legal_s, ebreak_s, wr_s, add_ok_s, rf_wen_s;

    assign opcode_s   = inst_q[6:0];
    assign rd_s       = inst_q[11:7];
    assign funct3_s   = inst_q[14:12];
    assign rs1_s      = inst_q[19:15];
    assign rs2_s      = inst_q[24:20];
    assign funct7_s   = inst_q[31:25];
    assign imm_i_s    = XLEN'($signed(inst_q[31:20]));
    assign imm_u_s    = XLEN'($signed({inst_q[31:12], 12'd0}));
    assign imm_j_s    = XLEN'($signed({inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0}));
    assign pc_plus4_s = pc_q + PC_STEP;
    assign jal_tgt_s  = pc_q + imm_j_s;
    assign jalr_tgt_s = (rs1_data_s + imm_i_s) & JALR_MASK;

    // Port 2 serves rs2 for a well-formed add; otherwise it reads a0 for halt_code.
    assign add_ok_s = (opcode_s == OP) && (funct3_s == 3'b000) && (funct7_s == 7'b0000000)
                   && reg_idx_ok(rd_s, NR_REGS) && reg_idx_ok(rs1_s, NR_REGS)
                   && reg_idx_ok(rs2_s, NR_REGS);
    assign raddr2_s = add_ok_s ? rs2_s : 5'd10;

    ysyx_23060303_regfile_p #(
        .XLEN    (XLEN),
        .NR_REGS (NR_REGS)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst),
        .raddr1 (rs1_s),
        .rdata1 (rs1_data_s),
        .raddr2 (raddr2_s),
        .rdata2 (rs2_data_s),
        .we     (rf_wen_s),
        .waddr  (rd_s),
        .wdata  (wdata_s)
    );

    // Decode and execute the held instruction: legality, write-back value, next pc.
    always_comb begin
        legal_s   = 1'b0;
        ebreak_s  = 1'b0;
        wr_s      = 1'b0;
        wdata_s   = '0;
        next_pc_s = pc_plus4_s;
        case (opcode_s)
            OP_IMM: begin
                if ((funct3_s == 3'b000) && reg_idx_ok(rd_s, NR_REGS) && reg_idx_ok(rs1_s, NR_REGS)) begin
                    legal_s = 1'b1;
                    wr_s    = 1'b1;
                    wdata_s = rs1_data_s + imm_i_s;
                end else begin
                    legal_s = 1'b0;
                end
            end
            OP: begin
                if (add_ok_s) begin
                    legal_s = 1'b1;
                    wr_s    = 1'b1;
                    wdata_s = rs1_data_s + rs2_data_s;
                end else begin
                    legal_s = 1'b0;
                end
            end
            LUI: begin
                if (reg_idx_ok(rd_s, NR_REGS)) begin
                    legal_s = 1'b1;
                    wr_s    = 1'b1;
                    wdata_s = imm_u_s;
                end else begin
                    legal_s = 1'b0;
                end
            end
            AUIPC: begin
                if (reg_idx_ok(rd_s, NR_REGS)) begin
                    legal_s = 1'b1;
                    wr_s    = 1'b1;
                    wdata_s = pc_q + imm_u_s;
                end else begin
                    legal_s = 1'b0;
                end
            end
            JAL: begin
                if (!jal_tgt_s[1] && reg_idx_ok(rd_s, NR_REGS)) begin
                    legal_s   = 1'b1;
                    wr_s      = 1'b1;
                    wdata_s   = pc_plus4_s;
                    next_pc_s = jal_tgt_s;
                end else begin
                    legal_s = 1'b0;
                end
            end
            JALR: begin
                if ((funct3_s == 3'b000) && !jalr_tgt_s[1] && reg_idx_ok(rd_s, NR_REGS)
                    && reg_idx_ok(rs1_s, NR_REGS)) begin
                    legal_s   = 1'b1;
                    wr_s      = 1'b1;
                    wdata_s   = pc_plus4_s;
                    next_pc_s = jalr_tgt_s;
                end else begin
                    legal_s = 1'b0;
                end
            end
            SYSTEM: begin
                if (inst_q == EBREAK_INST) begin
                    legal_s  = 1'b1;
                    ebreak_s = 1'b1;
                end else begin
                    legal_s = 1'b0;
                end
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    assign rf_wen_s = (state_q == EXEC) && legal_s && !ebreak_s && wr_s && (rd_s != 5'd0);

    // FSM next-state: request, capture, execute, halt.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        req_vld_d     = req_vld_q;
        halt_d        = halt_q;
        halt_reason_d = halt_reason_q;
        halt_code_d   = halt_code_q;
        case (state_q)
            FETCH: begin
                if (!req_vld_q) begin
                    req_vld_d = 1'b1;
                end else if (imem_req_rdy) begin
                    req_vld_d = 1'b0;
                    state_d   = WAIT;
                end else begin
                    req_vld_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rsp_vld) begin
                    inst_d  = imem_rsp_data;
                    state_d = EXEC;
                end else begin
                    state_d = WAIT;
                end
            end
            EXEC: begin
                if (ebreak_s) begin
                    state_d       = HALT;
                    halt_d        = 1'b1;
                    halt_reason_d = REASON_EBREAK;
                    halt_code_d   = rs2_data_s;
                end else if (!legal_s) begin
                    state_d       = HALT;
                    halt_d        = 1'b1;
                    halt_reason_d = REASON_ILLEGAL;
                    halt_code_d   = rs2_data_s;
                end else begin
                    state_d   = FETCH;
                    pc_d      = next_pc_s;
                    req_vld_d = 1'b1;
                end
            end
            HALT: begin
                req_vld_d = 1'b0;
            end
            default: begin
                state_d   = HALT;
                req_vld_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            inst_q        <= 32'h0000_0000;
            req_vld_q     <= 1'b0;
            halt_q        <= 1'b0;
            halt_reason_q <= REASON_NONE;
            halt_code_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            req_vld_q     <= req_vld_d;
            halt_q        <= halt_d;
            halt_reason_q <= halt_reason_d;
            halt_code_q   <= halt_code_d;
        end
    end

    assign imem_req_vld = req_vld_q;
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign halt         = halt_q;
    assign halt_reason  = halt_reason_q;
    assign halt_code    = halt_code_q;

`ifdef COMMIT_TRACE_EN
    logic            commit_vld_q, commit_vld_d;
    logic [XLEN-1:0] commit_pc_q;
    logic [31:0]     commit_inst_q;
    logic            commit_wen_q;
    logic [4:0]      commit_rd_q;
    logic [XLEN-1:0] commit_wdata_q;

    assign commit_vld_d = (state_q == EXEC) && legal_s;

    // Commit trace: one pulse per retired instruction, ebreak included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_vld_q   <= 1'b0;
            commit_pc_q    <= '0;
            commit_inst_q  <= 32'h0000_0000;
            commit_wen_q   <= 1'b0;
            commit_rd_q    <= 5'd0;
            commit_wdata_q <= '0;
        end else begin
            commit_vld_q   <= commit_vld_d;
            commit_pc_q    <= pc_q;
            commit_inst_q  <= inst_q;
            commit_wen_q   <= rf_wen_s;
            commit_rd_q    <= rd_s;
            commit_wdata_q <= wdata_s;
        end
    end

    assign commit_vld   = commit_vld_q;
    assign commit_pc    = commit_pc_q;
    assign commit_inst  = commit_inst_q;
    assign commit_wen   = commit_wen_q;
    assign commit_rd    = commit_rd_q;
    assign commit_wdata = commit_wdata_q;
`endif

endmodule
